// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit bus CPU control path: opcodes, micro-step
// width and the bit layout of the packed 15-line control word.
package cpu_defs;

  localparam int STEP_W = 3;
  localparam int OPC_W  = 4;
  localparam int CW_W   = 15;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA   = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDB   = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_LDI   = 4'h4;
  localparam logic [OPC_W-1:0] OP_STA   = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'h6;
  localparam logic [OPC_W-1:0] OP_MOVAB = 4'h7;
  localparam logic [OPC_W-1:0] OP_MOVAZ = 4'h8;
  localparam logic [OPC_W-1:0] OP_HLT   = 4'hF;

  localparam int CW_AI = 0;
  localparam int CW_AO = 1;
  localparam int CW_BI = 2;
  localparam int CW_BO = 3;
  localparam int CW_ZI = 4;
  localparam int CW_ZO = 5;
  localparam int CW_II = 6;
  localparam int CW_IO = 7;
  localparam int CW_CO = 8;
  localparam int CW_CE = 9;
  localparam int CW_J  = 10;
  localparam int CW_EO = 11;
  localparam int CW_MI = 12;
  localparam int CW_RI = 13;
  localparam int CW_RO = 14;

  typedef logic [CW_W-1:0] cw_t;

  // One-hot control word with only the given line asserted.
  function automatic cw_t cw_bit(input int idx);
    cw_t one;
    one    = {{(CW_W-1){1'b0}}, 1'b1};
    cw_bit = one << idx;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: {opcode, step} -> {control word, last step}.
// Steps past an opcode's end report last so the sequencer always recovers.
module microcode_rom
  import cpu_defs::*;
(
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [CW_W-1:0]   cw_o,
  output logic              last_o
);

  // Fetch is opcode-independent; the IR is only trusted from T2 on.
  always_comb begin
    cw_o   = {CW_W{1'b0}};
    last_o = 1'b0;
    case (step_i)
      3'd0: cw_o = cw_bit(CW_CO) | cw_bit(CW_MI);
      3'd1: cw_o = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
      default: begin
        case (opcode_i)
          OP_LDA, OP_LDB, OP_STA: begin
            case (step_i)
              3'd2: cw_o = cw_bit(CW_CO) | cw_bit(CW_MI);
              3'd3: cw_o = cw_bit(CW_RO) | cw_bit(CW_MI) | cw_bit(CW_CE);
              default: begin
                last_o = 1'b1;
                if (opcode_i == OP_LDA) begin
                  cw_o = cw_bit(CW_RO) | cw_bit(CW_AI);
                end else if (opcode_i == OP_LDB) begin
                  cw_o = cw_bit(CW_RO) | cw_bit(CW_BI);
                end else begin
                  cw_o = cw_bit(CW_AO) | cw_bit(CW_RI);
                end
              end
            endcase
          end
          OP_LDI, OP_JMP: begin
            if (step_i == 3'd2) begin
              cw_o = cw_bit(CW_CO) | cw_bit(CW_MI);
            end else begin
              last_o = 1'b1;
              if (opcode_i == OP_LDI) begin
                cw_o = cw_bit(CW_RO) | cw_bit(CW_AI) | cw_bit(CW_CE);
              end else begin
                cw_o = cw_bit(CW_RO) | cw_bit(CW_J);
              end
            end
          end
          OP_ADD: begin
            cw_o   = cw_bit(CW_EO) | cw_bit(CW_AI);
            last_o = 1'b1;
          end
          OP_MOVAB: begin
            cw_o   = cw_bit(CW_AO) | cw_bit(CW_BI);
            last_o = 1'b1;
          end
          OP_MOVAZ: begin
            cw_o   = cw_bit(CW_AO) | cw_bit(CW_ZI);
            last_o = 1'b1;
          end
          default: last_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcoded fetch/decode/execute sequencer driving every datapath control line.
// Holds the step counter and halt flag; gates all controls with reset/run/halt.
module control_unit
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [7:0]        instr,
  output logic              c_ai,
  output logic              c_ao,
  output logic              c_bi,
  output logic              c_bo,
  output logic              c_zi,
  output logic              c_zo,
  output logic              c_ii,
  output logic              c_io,
  output logic              c_co,
  output logic              c_ce,
  output logic              c_j,
  output logic              c_eo,
  output logic              c_mi,
  output logic              c_ri,
  output logic              c_ro,
  output logic              halt,
  output logic              instr_done,
  output logic [STEP_W-1:0] step
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic [CW_W-1:0]   rom_cw_s, cw_s;
  logic              rom_last_s, active_s;
  logic [3:0]        unused_instr_s;

  assign unused_instr_s = instr[3:0];

  microcode_rom u_rom (
    .opcode_i (instr[7:4]),
    .step_i   (step_q),
    .cw_o     (rom_cw_s),
    .last_o   (rom_last_s)
  );

  assign active_s = ~reset & run & ~halted_q;

  // Next step / halt state; a frozen or halted sequencer simply holds.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (active_s) begin
      if (rom_last_s) begin
        step_d = {STEP_W{1'b0}};
        if (instr[7:4] == OP_HLT) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end else begin
        step_d = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
      end
    end else begin
      step_d   = step_q;
      halted_d = halted_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= {STEP_W{1'b0}};
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign cw_s       = active_s ? rom_cw_s : {CW_W{1'b0}};
  assign instr_done = active_s & rom_last_s;
  assign halt       = halted_q;
  assign step       = step_q;

  assign c_ai = cw_s[CW_AI];
  assign c_ao = cw_s[CW_AO];
  assign c_bi = cw_s[CW_BI];
  assign c_bo = cw_s[CW_BO];
  assign c_zi = cw_s[CW_ZI];
  assign c_zo = cw_s[CW_ZO];
  assign c_ii = cw_s[CW_II];
  assign c_io = cw_s[CW_IO];
  assign c_co = cw_s[CW_CO];
  assign c_ce = cw_s[CW_CE];
  assign c_j  = cw_s[CW_J];
  assign c_eo = cw_s[CW_EO];
  assign c_mi = cw_s[CW_MI];
  assign c_ri = cw_s[CW_RI];
  assign c_ro = cw_s[CW_RO];

endmodule

// File: tb/tb_control_unit.sv
// Table-driven, scoreboarded bench for the control_unit sequencer.
module tb_control_unit;

  localparam logic [14:0] AI = 15'h0001, AO = 15'h0002, BI = 15'h0004, BO = 15'h0008;
  localparam logic [14:0] ZI = 15'h0010, ZO = 15'h0020, II = 15'h0040, IO = 15'h0080;
  localparam logic [14:0] CO = 15'h0100, CE = 15'h0200, JJ = 15'h0400, EO = 15'h0800;
  localparam logic [14:0] MI = 15'h1000, RI = 15'h2000, RO = 15'h4000, NONE = 15'h0000;

  typedef struct {
    logic        rst;
    logic        run;
    logic [7:0]  instr;
    logic [2:0]  step;
    logic [14:0] cw;
    logic        done;
    logic        halt;
  } vec_t;

  logic clk = 1'b0;
  logic reset, run;
  logic [7:0] instr;
  logic c_ai, c_ao, c_bi, c_bo, c_zi, c_zo, c_ii, c_io;
  logic c_co, c_ce, c_j, c_eo, c_mi, c_ri, c_ro;
  logic halt, instr_done;
  logic [2:0] step;
  logic [14:0] act_cw;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int failures = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .c_ai(c_ai), .c_ao(c_ao), .c_bi(c_bi), .c_bo(c_bo), .c_zi(c_zi), .c_zo(c_zo),
    .c_ii(c_ii), .c_io(c_io), .c_co(c_co), .c_ce(c_ce), .c_j(c_j), .c_eo(c_eo),
    .c_mi(c_mi), .c_ri(c_ri), .c_ro(c_ro),
    .halt(halt), .instr_done(instr_done), .step(step)
  );

  always #5 clk = ~clk;

  assign act_cw = {c_ro, c_ri, c_mi, c_eo, c_j, c_ce, c_co, c_io,
                   c_ii, c_zo, c_zi, c_bo, c_bi, c_ao, c_ai};

  task automatic add(input logic r, input logic rn, input logic [7:0] i,
                     input logic [2:0] s, input logic [14:0] cw,
                     input logic d, input logic h);
    vec_t v;
    v.rst = r; v.run = rn; v.instr = i; v.step = s; v.cw = cw; v.done = d; v.halt = h;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [7:0] i);
    add(1'b0, 1'b1, i, 3'd0, CO | MI, 1'b0, 1'b0);
    add(1'b0, 1'b1, i, 3'd1, RO | II | CE, 1'b0, 1'b0);
  endtask

  task automatic check_bus();
    checks++;
    if ($countones({c_ao, c_bo, c_zo, c_io, c_co, c_eo, c_ro}) > 1) begin
      failures++;
      $display("FAIL bus_onehot t=%0t drivers=%b", $time,
               {c_ao, c_bo, c_zo, c_io, c_co, c_eo, c_ro});
    end
  endtask

  initial begin
    vec_t e;
    int  exp_last [15];
    bit  seen;

    // Reset held 2 cycles, then NOP
    add(1'b1, 1'b1, 8'h00, 3'd0, NONE, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h00, 3'd0, NONE, 1'b0, 1'b0);
    fetch(8'h00);
    add(1'b0, 1'b1, 8'h00, 3'd2, NONE, 1'b1, 1'b0);
    // LDA, LDB
    fetch(8'h10);
    add(1'b0, 1'b1, 8'h10, 3'd2, CO | MI, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h10, 3'd3, RO | MI | CE, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h10, 3'd4, RO | AI, 1'b1, 1'b0);
    fetch(8'h20);
    add(1'b0, 1'b1, 8'h20, 3'd2, CO | MI, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd3, RO | MI | CE, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h20, 3'd4, RO | BI, 1'b1, 1'b0);
    // ADD, LDI, JMP
    fetch(8'h30);
    add(1'b0, 1'b1, 8'h30, 3'd2, EO | AI, 1'b1, 1'b0);
    fetch(8'h4C);
    add(1'b0, 1'b1, 8'h4C, 3'd2, CO | MI, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h4C, 3'd3, RO | AI | CE, 1'b1, 1'b0);
    fetch(8'h60);
    add(1'b0, 1'b1, 8'h60, 3'd2, CO | MI, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h60, 3'd3, RO | JJ, 1'b1, 1'b0);
    // MOVAB, MOVAZ, undefined opcodes
    fetch(8'h70);
    add(1'b0, 1'b1, 8'h70, 3'd2, AO | BI, 1'b1, 1'b0);
    fetch(8'h85);
    add(1'b0, 1'b1, 8'h85, 3'd2, AO | ZI, 1'b1, 1'b0);
    fetch(8'h9A);
    add(1'b0, 1'b1, 8'h9A, 3'd2, NONE, 1'b1, 1'b0);
    fetch(8'hE0);
    add(1'b0, 1'b1, 8'hE0, 3'd2, NONE, 1'b1, 1'b0);
    // STA with run dropped for 3 cycles at T3
    fetch(8'h50);
    add(1'b0, 1'b1, 8'h50, 3'd2, CO | MI, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 8'h50, 3'd3, NONE, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h50, 3'd3, RO | MI | CE, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h50, 3'd4, AO | RI, 1'b1, 1'b0);
    // Reset at T3 of LDA abandons it; fresh fetch of a NOP follows
    fetch(8'h10);
    add(1'b0, 1'b1, 8'h10, 3'd2, CO | MI, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h10, 3'd3, NONE, 1'b0, 1'b0);
    fetch(8'h00);
    add(1'b0, 1'b1, 8'h00, 3'd2, NONE, 1'b1, 1'b0);
    // HLT, 20 halted cycles, reset out, fresh fetch
    fetch(8'hF0);
    add(1'b0, 1'b1, 8'hF0, 3'd2, NONE, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) add(1'b0, 1'b1, 8'hF0, 3'd0, NONE, 1'b0, 1'b1);
    add(1'b1, 1'b1, 8'hF0, 3'd0, NONE, 1'b0, 1'b1);
    fetch(8'h00);
    add(1'b0, 1'b1, 8'h00, 3'd2, NONE, 1'b1, 1'b0);

    reset = 1'b1; run = 1'b0; instr = 8'h00;
    @(posedge clk); #1;

    foreach (vecs[n]) begin
      reset = vecs[n].rst; run = vecs[n].run; instr = vecs[n].instr;
      sb.push_back(vecs[n]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (act_cw !== e.cw || step !== e.step || instr_done !== e.done || halt !== e.halt) begin
        failures++;
        $display("FAIL vec%0d instr=%h got cw=%h step=%0d done=%b halt=%b want cw=%h step=%0d done=%b halt=%b",
                 n, e.instr, act_cw, step, instr_done, halt, e.cw, e.step, e.done, e.halt);
      end
      check_bus();
      @(posedge clk); #1;
    end

    // Opcode sweep: final step of each non-halting opcode, bounded wait
    exp_last = '{2, 4, 4, 2, 3, 4, 3, 2, 2, 2, 2, 2, 2, 2, 2};
    for (int op = 0; op < 15; op++) begin
      reset = 1'b1; run = 1'b1; instr = 8'(op << 4);
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clk);
        check_bus();
        if (instr_done === 1'b1) begin
          seen = 1'b1;
          checks++;
          if (step !== 3'(exp_last[op])) begin
            failures++;
            $display("FAIL sweep_last op=%h got step=%0d want %0d", op, step, exp_last[op]);
          end
        end
        @(posedge clk); #1;
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL sweep_timeout op=%h got no instr_done want done by step %0d", op, exp_last[op]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Microcoded sequencer for the 8-bit bus CPU.
- Sits directly upstream of the datapath. It consumes the instruction register output and drives every bus/register control line (c_ai, c_ao, c_mi, c_ro, …) that the register, PC, ALU and memory blocks currently receive as hand-set regs.
- Runs a fetch/decode/execute step counter. Instructions are 1 or 2 bytes: opcode byte, then optional operand byte.

Parameters:
STEP_W, 3, width of the micro-step counter (T0..T7 addressable; T0..T4 used)
OPC_W, 4, opcode field width, taken from instr[7:4]; instr[3:0] ignored

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears step counter and halt state
run  input  1  1 = advance; 0 = freeze step and force all control lines low
instr  input  8  instruction register contents (regI_bus)
c_ai, c_ao, c_bi, c_bo, c_zi, c_zo, c_ii, c_io  output  1 each  register load/drive enables
c_co, c_ce, c_j  output  1 each  PC drive, increment, load
c_eo  output  1  ALU sum drive
c_mi, c_ri, c_ro  output  1 each  MAR load, RAM write, RAM drive
halt  output  1  high while halted
instr_done  output  1  high during the final micro-step of each instruction
step  output  STEP_W  current micro-step (debug)

Behaviour:
- Control outputs are combinational from (step, instr[7:4], halted, run, reset).
  - While reset=1 or run=0, every control output = 0.
  - Step register is STEP_W bits; reset value 0.
  - halted flag resets to 0.
- Step advance (run=1, not halted):
  - step <= 0 when the current step is the opcode's last step.
  - Otherwise step <= step+1.
  - run=0 holds step.
- Fetch, common to all opcodes:
  - T0: co, mi.
  - T1: ro, ii, ce.
  - instr is valid from T2 onward. Decode never uses instr in T0/T1.
- Execute steps (last step marked *, which also asserts instr_done):
  - 0x0 NOP: T2* none.
  - 0x1 LDA addr: T2 co,mi; T3 ro,mi,ce; T4* ro,ai.
  - 0x2 LDB addr: T2 co,mi; T3 ro,mi,ce; T4* ro,bi.
  - 0x3 ADD: T2* eo,ai (A <= A+B).
  - 0x4 LDI imm: T2 co,mi; T3* ro,ai,ce.
  - 0x5 STA addr: T2 co,mi; T3 ro,mi,ce; T4* ao,ri.
  - 0x6 JMP addr: T2 co,mi; T3* ro,j.
  - 0x7 MOVAB: T2* ao,bi.
  - 0x8 MOVAZ: T2* ao,zi.
  - 0xF HLT: T2* none. On this edge halted <= 1 and step <= 0.
  - Undefined 0x9..0xE: behave as NOP.
- Halted state: halt=1, all control lines 0, step frozen at 0. Only reset exits.
- c_ce and c_j are high for exactly one clk cycle per use. Never hold them across cycles.
- Bus invariant: at most one of {ao,bo,zo,io,co,eo,ro} high in any cycle.
- Reset mid-instruction: on the next edge step=0. The following cycle is a fresh T0 fetch; the partial instruction is abandoned.
- run deasserted mid-instruction: resumes at the same step, with no repeated or skipped control pulses.

Decomposition:
- Shared package cpu_defs:
  - opcode localparams (OP_NOP..OP_HLT);
  - STEP_W;
  - control-word bit indices (CW_AI..CW_RO), packing the 15 control lines into one word.
- One sub-module microcode_rom: pure combinational map {opcode, step} -> {control word, last}.
- control_unit holds the step counter, the halted flag, and the reset/run gating.

Test Plan:
- Reset held 2 cycles, then run=1 with instr=0x00 (NOP) → cycles show T0 {co,mi}, T1 {ro,ii,ce}, T2 {instr_done}; step sequence 0,1,2,0.
- instr=0x10 (LDA) → T2 {co,mi}, T3 {ro,mi,ce}, T4 {ro,ai,instr_done}; c_ce pulses exactly twice per instruction (T1, T3).
- instr=0x60 (JMP) → T3 {ro,j}, c_ce absent in T3; next cycle step=0 with {co,mi}.
- instr=0xF0 (HLT) → after T2 edge halt=1, all controls 0 for 20 cycles; reset pulse → halt=0, step=0, next T0 {co,mi}.
- instr=0x50 (STA), drop run at T3 for 3 cycles → controls 0, step stays 3; on resume T3 {ro,mi,ce} once, then T4 {ao,ri}.
- Reset asserted at T3 of LDA → next cycle step=0; the T4 {ro,ai} pattern never appears. Bus-driver one-hot assertion holds across all opcodes 0x0–0xF.
